mult_div_ctrl_seq: RTL and testbench

//  Control sequencer for the multiplier/divider datapath (A, B, C[31:0], D counter, done, neg1, neg2, mult_div).

---
 rtl/mult_div_ctrl_seq.sv | 212 +++++++++++++++++++++
 tb/tb_mult_div_ctrl_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_ctrl_seq.sv
// mult_div_ctrl_seq: control sequencer for the 16-bit shift-and-add multiplier and the
// 16-bit restoring divider datapath.
//   clk_i, reset_i          clock, asynchronous active-high reset
//   start_i, mult_div_i     request (sampled in IDLE), 1 = multiply / 0 = divide
//   a_lsb_i, a_zero_i       A[0] and A == 0 from the datapath
//   d_zero_i, z_neg_i       D == 0 (pre-decrement) and sign of CHi - A
//   neg1_i, neg2_i          captured operand signs
//   init_*_o, ld_*_o,       datapath strobes, registered, stable for a whole cycle
//   shift_*_o, set_q_o
//   alu_sel_o               0 PASS, 1 C+B, 2 CHi-A, 3 D-1, 4 -C, 5 -CLo
//   busy_o, done_1_o        busy outside IDLE, one-cycle completion strobe
//   div_err_o               divide by zero, sticky until the next accepted start
module mult_div_ctrl_seq #(
   parameter int unsigned ALU_W   = 3,
   parameter bit          ONE_HOT = 1'b0
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic             mult_div_i,
   input  logic             a_lsb_i,
   input  logic             a_zero_i,
   input  logic             d_zero_i,
   input  logic             z_neg_i,
   input  logic             neg1_i,
   input  logic             neg2_i,
   output logic             init_mult_o,
   output logic             init_div_o,
   output logic             ld_c_z_o,
   output logic             ld_chi_z_o,
   output logic             ld_clo_z_o,
   output logic             ld_d_z_o,
   output logic             shift_a_o,
   output logic             shift_b_o,
   output logic             shift_c_l_o,
   output logic             set_q_o,
   output logic [ALU_W-1:0] alu_sel_o,
   output logic             busy_o,
   output logic             done_1_o,
   output logic             div_err_o
);

   localparam int unsigned StW = ONE_HOT ? 11 : 4;

   typedef enum logic [StW-1:0] {
      StIdle     = StW'(ONE_HOT ? (1 << 0)  : 0),
      StInit     = StW'(ONE_HOT ? (1 << 1)  : 1),
      StMulTest  = StW'(ONE_HOT ? (1 << 2)  : 2),
      StMulAdd   = StW'(ONE_HOT ? (1 << 3)  : 3),
      StMulShift = StW'(ONE_HOT ? (1 << 4)  : 4),
      StMulDec   = StW'(ONE_HOT ? (1 << 5)  : 5),
      StDivShl   = StW'(ONE_HOT ? (1 << 6)  : 6),
      StDivSub   = StW'(ONE_HOT ? (1 << 7)  : 7),
      StDivDec   = StW'(ONE_HOT ? (1 << 8)  : 8),
      StFix      = StW'(ONE_HOT ? (1 << 9)  : 9),
      StDone     = StW'(ONE_HOT ? (1 << 10) : 10)
   } state_e;

   localparam logic [ALU_W-1:0] AluPass  = ALU_W'(0);
   localparam logic [ALU_W-1:0] AluAdd   = ALU_W'(1);
   localparam logic [ALU_W-1:0] AluSub   = ALU_W'(2);
   localparam logic [ALU_W-1:0] AluDec   = ALU_W'(3);
   localparam logic [ALU_W-1:0] AluNeg   = ALU_W'(4);
   localparam logic [ALU_W-1:0] AluNegLo = ALU_W'(5);

   state_e           state_q, state_d;
   logic             mul_q, mul_d;
   logic             dz_q, dz_d;   // d_zero as seen on entry to a DEC state
   logic             init_mult_d, init_div_d, ld_c_z_d, ld_chi_z_d, ld_clo_z_d, ld_d_z_d;
   logic             shift_a_d, shift_b_d, shift_c_l_d, set_q_d, busy_d, done_1_d, div_err_d;
   logic [ALU_W-1:0] alu_sel_d;

   always_comb begin
      state_d     = state_q;
      mul_d       = mul_q;
      dz_d        = dz_q;
      div_err_d   = div_err_o;
      init_mult_d = 1'b0;
      init_div_d  = 1'b0;
      ld_c_z_d    = 1'b0;
      ld_chi_z_d  = 1'b0;
      ld_clo_z_d  = 1'b0;
      ld_d_z_d    = 1'b0;
      shift_a_d   = 1'b0;
      shift_b_d   = 1'b0;
      shift_c_l_d = 1'b0;
      set_q_d     = 1'b0;
      done_1_d    = 1'b0;
      alu_sel_d   = AluPass;

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StInit;
               mul_d   = mult_div_i;
            end
         end
         StInit: begin
            if (mul_q) begin
               state_d = StMulTest;
            end else if (a_zero_i) begin
               state_d   = StDone;
               div_err_d = 1'b1;
            end else begin
               state_d = StDivShl;
            end
         end
         StMulTest:  state_d = a_lsb_i ? StMulAdd : StMulShift;
         StMulAdd:   state_d = StMulShift;
         StMulShift: begin
            state_d = StMulDec;
            dz_d    = d_zero_i;
         end
         StMulDec:   state_d = dz_q ? StFix : StMulTest;
         StDivShl:   state_d = StDivSub;
         StDivSub: begin
            state_d = StDivDec;
            dz_d    = d_zero_i;
         end
         StDivDec:   state_d = dz_q ? StFix : StDivShl;
         StFix:      state_d = StDone;
         StDone:     state_d = StIdle;
         default:    state_d = StIdle;
      endcase

      // Outputs are a function of the state being entered, so they are stable all cycle.
      busy_d = (state_d != StIdle);
      unique case (state_d)
         StInit: begin
            init_mult_d = mul_d;
            init_div_d  = ~mul_d;
            div_err_d   = 1'b0;
         end
         StMulAdd: begin
            alu_sel_d = AluAdd;
            ld_c_z_d  = 1'b1;
         end
         StMulShift: begin
            shift_a_d = 1'b1;
            shift_b_d = 1'b1;
         end
         StMulDec, StDivDec: begin
            alu_sel_d = AluDec;
            ld_d_z_d  = 1'b1;
         end
         StDivShl: begin
            shift_c_l_d = 1'b1;
            // Preselect CHi-A so z_neg has settled on the shifted C by the DIV_SUB entry edge.
            alu_sel_d   = AluSub;
         end
         StDivSub: begin
            alu_sel_d  = AluSub;
            ld_chi_z_d = ~z_neg_i;
            set_q_d    = ~z_neg_i;
         end
         StFix: begin
            if (neg1_i ^ neg2_i) begin
               if (mul_q) begin
                  alu_sel_d = AluNeg;
                  ld_c_z_d  = 1'b1;
               end else begin
                  alu_sel_d  = AluNegLo;
                  ld_clo_z_d = 1'b1;
               end
            end
         end
         StDone:  done_1_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= StIdle;
         mul_q       <= 1'b0;
         dz_q        <= 1'b0;
         init_mult_o <= 1'b0;
         init_div_o  <= 1'b0;
         ld_c_z_o    <= 1'b0;
         ld_chi_z_o  <= 1'b0;
         ld_clo_z_o  <= 1'b0;
         ld_d_z_o    <= 1'b0;
         shift_a_o   <= 1'b0;
         shift_b_o   <= 1'b0;
         shift_c_l_o <= 1'b0;
         set_q_o     <= 1'b0;
         alu_sel_o   <= AluPass;
         busy_o      <= 1'b0;
         done_1_o    <= 1'b0;
         div_err_o   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mul_q       <= mul_d;
         dz_q        <= dz_d;
         init_mult_o <= init_mult_d;
         init_div_o  <= init_div_d;
         ld_c_z_o    <= ld_c_z_d;
         ld_chi_z_o  <= ld_chi_z_d;
         ld_clo_z_o  <= ld_clo_z_d;
         ld_d_z_o    <= ld_d_z_d;
         shift_a_o   <= shift_a_d;
         shift_b_o   <= shift_b_d;
         shift_c_l_o <= shift_c_l_d;
         set_q_o     <= set_q_d;
         alu_sel_o   <= alu_sel_d;
         busy_o      <= busy_d;
         done_1_o    <= done_1_d;
         div_err_o   <= div_err_d;
      end
   end

endmodule

// File: tb/tb_mult_div_ctrl_seq.sv
// tb_mult_div_ctrl_seq: drives mult_div_ctrl_seq against a behavioural A/B/C/D datapath and
// ALU, and checks results, latencies, strobe counts, div_err and reset behaviour.
module tb_mult_div_ctrl_seq;

   logic clk = 1'b0;
   logic reset, start, mult_div;
   logic a_lsb, a_zero, d_zero, z_neg, neg1, neg2;
   logic init_mult, init_div, ld_c_z, ld_chi_z, ld_clo_z, ld_d_z;
   logic shift_a, shift_b, shift_c_l, set_q, busy, done_1, div_err;
   logic [2:0] alu_sel;

   always #5 clk = ~clk;

   mult_div_ctrl_seq #(.ALU_W(3), .ONE_HOT(1'b0)) dut (
      .clk_i(clk), .reset_i(reset), .start_i(start), .mult_div_i(mult_div),
      .a_lsb_i(a_lsb), .a_zero_i(a_zero), .d_zero_i(d_zero), .z_neg_i(z_neg),
      .neg1_i(neg1), .neg2_i(neg2),
      .init_mult_o(init_mult), .init_div_o(init_div), .ld_c_z_o(ld_c_z),
      .ld_chi_z_o(ld_chi_z), .ld_clo_z_o(ld_clo_z), .ld_d_z_o(ld_d_z),
      .shift_a_o(shift_a), .shift_b_o(shift_b), .shift_c_l_o(shift_c_l), .set_q_o(set_q),
      .alu_sel_o(alu_sel), .busy_o(busy), .done_1_o(done_1), .div_err_o(div_err)
   );

   // Behavioural datapath: registers capture at the falling clock edge while strobed.
   logic [15:0] op1, op2, a_r;
   logic [31:0] b_r, c_r, z;
   logic [3:0]  d_r;
   logic [16:0] sub;

   always @(negedge clk) begin
      if (init_mult) begin
         a_r <= op1; b_r <= {16'h0, op2}; c_r <= 32'h0; d_r <= 4'hF;
      end
      if (init_div) begin
         a_r <= op2; b_r <= 32'h0; c_r <= {16'h0, op1}; d_r <= 4'hF;
      end
      if (ld_c_z)    c_r <= z;
      if (ld_chi_z)  c_r[31:16] <= z[15:0];
      if (ld_clo_z)  c_r[15:0] <= z[15:0];
      if (set_q)     c_r[0] <= 1'b1;
      if (ld_d_z)    d_r <= z[3:0];
      if (shift_a)   a_r <= a_r >> 1;
      if (shift_b)   b_r <= b_r << 1;
      if (shift_c_l) c_r <= c_r << 1;
   end

   always_comb begin
      sub = {1'b0, c_r[31:16]} - {1'b0, a_r};
      z   = 32'h0;
      case (alu_sel)
         3'd0:    z = c_r;
         3'd1:    z = c_r + b_r;
         3'd2:    z = {15'h0, sub};
         3'd3:    z = {28'h0, d_r - 4'd1};
         3'd4:    z = -c_r;
         3'd5:    z = {16'h0, -c_r[15:0]};
         default: z = 32'h0;
      endcase
      a_lsb  = a_r[0];
      a_zero = (a_r == 16'h0);
      d_zero = (d_r == 4'h0);
      z_neg  = (alu_sel == 3'd2) && sub[16];
   end

   int checks = 0;
   int errors = 0;
   int overlap = 0;
   bit prev_err = 1'b0;

   always @(negedge clk) begin
      if (!reset && !$onehot0({ld_c_z, ld_chi_z, ld_clo_z, ld_d_z})) overlap <= overlap + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      bit          mul;
      logic [15:0] op1;
      logic [15:0] op2;
      bit          n1;
      bit          n2;
      logic [31:0] exp_c;
      int          exp_lat;
      int          exp_adds;
      bit          exp_err;
   } vec_t;

   vec_t vecs[10];

   task automatic run_op(input vec_t v, input int idx);
      int cyc = 0, done_cyc = 0, adds = 0, shifts = 0;
      bit seen = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d idle_busy", idx), 32'(busy), 32'd0);
      check($sformatf("v%0d err_sticky", idx), 32'(div_err), 32'(prev_err));
      op1 = v.op1; op2 = v.op2; neg1 = v.n1; neg2 = v.n2; mult_div = v.mul; start = 1'b1;
      @(negedge clk);
      cyc   = 1;
      start = 1'b0;
      check($sformatf("v%0d init_strobes", idx), {30'h0, init_mult, init_div},
            v.mul ? 32'd2 : 32'd1);
      check($sformatf("v%0d err_cleared", idx), 32'(div_err), 32'd0);
      while (!seen && cyc < 200) begin
         if (ld_c_z && alu_sel == 3'd1) adds++;
         if (shift_a || shift_b || shift_c_l) shifts++;
         if (done_1) begin
            seen     = 1'b1;
            done_cyc = cyc;
            check($sformatf("v%0d done_busy", idx), 32'(busy), 32'd1);
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      check($sformatf("v%0d latency", idx), 32'(done_cyc), 32'(v.exp_lat));
      check($sformatf("v%0d result_c", idx), c_r, v.exp_c);
      check($sformatf("v%0d add_pulses", idx), 32'(adds), 32'(v.exp_adds));
      check($sformatf("v%0d shift_cycles", idx), 32'(shifts), v.exp_err ? 32'd0 : 32'd16);
      check($sformatf("v%0d div_err", idx), 32'(div_err), 32'(v.exp_err));
      @(negedge clk);
      check($sformatf("v%0d after_done", idx), {30'h0, busy, done_1}, 32'd0);
      check($sformatf("v%0d err_holds", idx), 32'(div_err), 32'(v.exp_err));
      prev_err = v.exp_err;
   endtask

   initial begin
      int dones;
      int done_at[4];

      //          mul   op1       op2       n1    n2    exp_c          lat adds err
      vecs[0] = '{1'b1, 16'd3,    16'd5,    1'b0, 1'b0, 32'h0000000F,  53, 2,  1'b0};
      vecs[1] = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 32'hFFFE0001,  67, 16, 1'b0};
      vecs[2] = '{1'b1, 16'd0,    16'd7,    1'b0, 1'b0, 32'h00000000,  51, 0,  1'b0};
      vecs[3] = '{1'b1, 16'd3,    16'd5,    1'b1, 1'b0, 32'hFFFFFFF1,  53, 2,  1'b0};
      vecs[4] = '{1'b0, 16'd100,  16'd7,    1'b0, 1'b0, 32'h0002000E,  51, 0,  1'b0};
      vecs[5] = '{1'b0, 16'd100,  16'd7,    1'b1, 1'b0, 32'h0002FFF2,  51, 0,  1'b0};
      vecs[6] = '{1'b0, 16'd5,    16'd0,    1'b0, 1'b0, 32'h00000005,  2,  0,  1'b1};
      vecs[7] = '{1'b1, 16'h1234, 16'h0010, 1'b1, 1'b1, 32'h00012340,  56, 5,  1'b0};
      vecs[8] = '{1'b0, 16'hFFFF, 16'd1,    1'b0, 1'b1, 32'h00000001,  51, 0,  1'b0};
      vecs[9] = '{1'b0, 16'd7,    16'd100,  1'b0, 1'b0, 32'h00070000,  51, 0,  1'b0};

      reset = 1'b1; start = 1'b0; mult_div = 1'b0; neg1 = 1'b0; neg2 = 1'b0;
      op1 = 16'h0; op2 = 16'h0;
      repeat (2) @(negedge clk);
      check("reset_outputs", {16'h0, init_mult, init_div, ld_c_z, ld_chi_z, ld_clo_z, ld_d_z,
            shift_a, shift_b, shift_c_l, set_q, busy, done_1, div_err, alu_sel}, 32'h0);
      reset = 1'b0;

      for (int i = 0; i < 10; i++) run_op(vecs[i], i);

      // Reset pulsed during iteration 7 of a long multiply.
      @(negedge clk);
      op1 = 16'hFFFF; op2 = 16'd1; neg1 = 1'b0; neg2 = 1'b0; mult_div = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (26) @(negedge clk);
      check("midop_busy", 32'(busy), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("midop_reset_outputs", {16'h0, init_mult, init_div, ld_c_z, ld_chi_z, ld_clo_z,
            ld_d_z, shift_a, shift_b, shift_c_l, set_q, busy, done_1, div_err, alu_sel}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      dones = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (done_1 || busy) dones++;
      end
      check("no_done_after_reset", 32'(dones), 32'd0);
      prev_err = 1'b0;
      run_op(vecs[1], 10);

      // Start held high: one op per IDLE visit, done_1 every 52 cycles.
      @(negedge clk);
      op1 = 16'd0; op2 = 16'd7; neg1 = 1'b0; neg2 = 1'b0; mult_div = 1'b1; start = 1'b1;
      dones = 0;
      for (int cyc = 1; cyc <= 160; cyc++) begin
         @(negedge clk);
         if (done_1) begin
            if (dones < 4) done_at[dones] = cyc;
            dones++;
         end
         if (cyc == 52) check("held_idle_visit", 32'(busy), 32'd0);
         if (cyc == 53) check("held_restart", 32'(init_mult), 32'd1);
      end
      start = 1'b0;
      check("held_done_count", 32'(dones), 32'd3);
      for (int k = 0; k < 3; k++) begin
         if (k < dones) check($sformatf("held_done_%0d", k), 32'(done_at[k]), 32'(51 + 52 * k));
      end
      @(negedge clk);
      check("ld_onehot0", 32'(overlap), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
